// File: rtl/register_bank_pkg.sv
// ============================================================================
// register_bank_pkg : shared select codes and interrupt FSM state encodings
// Revision : 1.0
// ============================================================================
`default_nettype none

package register_bank_pkg;

  // Read/write select codes shared with the write-back and decode stages
  localparam logic [3:0] SEL_ZERO = 4'd0;
  localparam logic [3:0] SEL_R1   = 4'd1;
  localparam logic [3:0] SEL_R2   = 4'd2;
  localparam logic [3:0] SEL_R3   = 4'd3;
  localparam logic [3:0] SEL_R4   = 4'd4;
  localparam logic [3:0] SEL_R5   = 4'd5;
  localparam logic [3:0] SEL_R6   = 4'd6;
  localparam logic [3:0] SEL_R7   = 4'd7;
  localparam logic [3:0] SEL_R8   = 4'd8;
  localparam logic [3:0] SEL_FLAG = 4'd9;
  localparam logic [3:0] SEL_RSVD = 4'd10;
  localparam logic [3:0] SEL_TPC  = 4'd11;
  localparam logic [3:0] SEL_IPC  = 4'd12;
  localparam logic [3:0] SEL_SP   = 4'd13;
  localparam logic [3:0] SEL_TLB  = 4'd14;
  localparam logic [3:0] SEL_NONE = 4'd15;

  typedef enum logic [0:0] {
    INT_IDLE    = 1'b0,
    INT_PENDING = 1'b1
  } int_state_e;

  // True for codes backed by a physical register; the rest read as zero
  function automatic logic is_reg_sel(input logic [3:0] sel);
    return !((sel == SEL_ZERO) || (sel == SEL_RSVD) || (sel == SEL_NONE));
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_bank_if.sv
// ============================================================================
// register_bank_if : write-back, read-port and interrupt signals of the bank
// Revision : 1.0
// ============================================================================
`default_nettype none

interface register_bank_if;

  logic [31:0] r1, r2, r3, r4, r5, r6, r7, r8;
  logic [31:0] flag, tpc, ipc, sp, tlb;
  logic        r1_c, r2_c, r3_c, r4_c, r5_c, r6_c, r7_c, r8_c;
  logic        flag_c, tpc_c, ipc_c, sp_c, tlb_c;
  logic        int_in;
  logic [7:0]  int_num_in;
  logic        int_ack;
  logic [3:0]  rd_a_sel, rd_b_sel;
  logic [31:0] rd_a_data, rd_b_data;
  logic [31:0] flag_q, tpc_q, ipc_q, sp_q, tlb_q;
  logic        int_pending;
  logic [7:0]  int_num_q;
  logic        int_overrun;

  modport master (
    output r1, r2, r3, r4, r5, r6, r7, r8, flag, tpc, ipc, sp, tlb,
    output r1_c, r2_c, r3_c, r4_c, r5_c, r6_c, r7_c, r8_c,
    output flag_c, tpc_c, ipc_c, sp_c, tlb_c,
    output int_in, int_num_in, int_ack, rd_a_sel, rd_b_sel,
    input  rd_a_data, rd_b_data, flag_q, tpc_q, ipc_q, sp_q, tlb_q,
    input  int_pending, int_num_q, int_overrun
  );

  modport slave (
    input  r1, r2, r3, r4, r5, r6, r7, r8, flag, tpc, ipc, sp, tlb,
    input  r1_c, r2_c, r3_c, r4_c, r5_c, r6_c, r7_c, r8_c,
    input  flag_c, tpc_c, ipc_c, sp_c, tlb_c,
    input  int_in, int_num_in, int_ack, rd_a_sel, rd_b_sel,
    output rd_a_data, rd_b_data, flag_q, tpc_q, ipc_q, sp_q, tlb_q,
    output int_pending, int_num_q, int_overrun
  );

endinterface

`default_nettype wire

// File: rtl/register_bank_int_latch.sv
// ============================================================================
// int_latch : holds one pending interrupt vector until acknowledged
// Revision : 1.0
// ============================================================================
`default_nettype none

module int_latch
  import register_bank_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       int_in,
  input  wire logic [7:0] int_num_in,
  input  wire logic       int_ack,
  output logic            int_pending,
  output logic [7:0]      int_num_q,
  output logic            int_overrun
);

  int_state_e state_q, state_d;
  logic [7:0] int_num_d;
  logic       overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    int_num_d = int_num_q;
    overrun_d = overrun_q;
    case (state_q)
      INT_IDLE: begin
        if (int_in) begin
          state_d   = INT_PENDING;
          int_num_d = int_num_in;
        end
      end
      INT_PENDING: begin
        // Ack and a new request together hand over to the new vector
        if (int_ack && int_in) begin
          int_num_d = int_num_in;
        end else if (int_ack) begin
          state_d = INT_IDLE;
        end else if (int_in) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = INT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INT_IDLE;
      int_num_q <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_num_q <= int_num_d;
      overrun_q <= overrun_d;
    end
  end

  assign int_pending = (state_q == INT_PENDING);
  assign int_overrun = overrun_q;

endmodule

`default_nettype wire

// File: rtl/register_bank.sv
// ============================================================================
// register_bank : general and special registers with bypassed read ports
// Revision : 1.0
// ============================================================================
`default_nettype none

module register_bank
  import register_bank_pkg::*;
#(
  parameter logic [31:0] SP_RESET  = 32'h0000_0000,
  parameter logic [31:0] TPC_RESET = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  register_bank_if.slave   bus
);

  logic [15:0] wr_en;
  logic [31:0] wr_data [16];
  logic [31:0] regs_q  [16];

  // Flatten the write-back ports into arrays indexed by select code
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < 16; i++) begin
      wr_data[i] = '0;
    end
    wr_en[SEL_R1]   = bus.r1_c;   wr_data[SEL_R1]   = bus.r1;
    wr_en[SEL_R2]   = bus.r2_c;   wr_data[SEL_R2]   = bus.r2;
    wr_en[SEL_R3]   = bus.r3_c;   wr_data[SEL_R3]   = bus.r3;
    wr_en[SEL_R4]   = bus.r4_c;   wr_data[SEL_R4]   = bus.r4;
    wr_en[SEL_R5]   = bus.r5_c;   wr_data[SEL_R5]   = bus.r5;
    wr_en[SEL_R6]   = bus.r6_c;   wr_data[SEL_R6]   = bus.r6;
    wr_en[SEL_R7]   = bus.r7_c;   wr_data[SEL_R7]   = bus.r7;
    wr_en[SEL_R8]   = bus.r8_c;   wr_data[SEL_R8]   = bus.r8;
    wr_en[SEL_FLAG] = bus.flag_c; wr_data[SEL_FLAG] = bus.flag;
    wr_en[SEL_TPC]  = bus.tpc_c;  wr_data[SEL_TPC]  = bus.tpc;
    wr_en[SEL_IPC]  = bus.ipc_c;  wr_data[SEL_IPC]  = bus.ipc;
    wr_en[SEL_SP]   = bus.sp_c;   wr_data[SEL_SP]   = bus.sp;
    wr_en[SEL_TLB]  = bus.tlb_c;  wr_data[SEL_TLB]  = bus.tlb;
  end

  for (genvar g = 0; g < 16; g++) begin : g_reg
    if (is_reg_sel(4'(g))) begin : g_flop
      localparam logic [31:0] RST_VAL = (4'(g) == SEL_SP)  ? SP_RESET  :
                                        (4'(g) == SEL_TPC) ? TPC_RESET : 32'h0;
      logic [31:0] reg_d, reg_q;

      always_comb begin
        reg_d = reg_q;
        if (wr_en[g]) begin
          reg_d = wr_data[g];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          reg_q <= RST_VAL;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs_q[g] = reg_q;
    end else begin : g_zero
      assign regs_q[g] = 32'h0;
    end
  end

  // Unbacked codes have wr_en=0 and regs_q=0, so they read zero here too
  assign bus.rd_a_data = wr_en[bus.rd_a_sel] ? wr_data[bus.rd_a_sel] : regs_q[bus.rd_a_sel];
  assign bus.rd_b_data = wr_en[bus.rd_b_sel] ? wr_data[bus.rd_b_sel] : regs_q[bus.rd_b_sel];

  assign bus.flag_q = regs_q[SEL_FLAG];
  assign bus.tpc_q  = regs_q[SEL_TPC];
  assign bus.ipc_q  = regs_q[SEL_IPC];
  assign bus.sp_q   = regs_q[SEL_SP];
  assign bus.tlb_q  = regs_q[SEL_TLB];

  int_latch u_int_latch (
    .clk         (clk),
    .rst         (rst),
    .int_in      (bus.int_in),
    .int_num_in  (bus.int_num_in),
    .int_ack     (bus.int_ack),
    .int_pending (bus.int_pending),
    .int_num_q   (bus.int_num_q),
    .int_overrun (bus.int_overrun)
  );

endmodule

`default_nettype wire

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter SP_RESET, default 32'h0000_0000, reset value of sp.
REQ-002 Parameter TPC_RESET, default 32'h0000_0000, reset value of tpc.
REQ-003 The clock input is clk, the reset input is rst, and rst SHALL be synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 Write data inputs r1..r8, flag, tpc, ipc, sp, tlb: each in, 32 bits, write-back data per register.
REQ-007 Write enable inputs r1_c..r8_c, flag_c, tpc_c, ipc_c, sp_c, tlb_c: each in, 1 bit, write enable per register.
REQ-008 int_in  in  1  interrupt request from write-back (next_interrupt).
REQ-009 int_num_in  in  8  vector number accompanying int_in.
REQ-010 int_ack  in  1  control unit accepts the pending interrupt.
REQ-011 rd_a_sel, rd_b_sel  in  4  read-port register selects.
REQ-012 rd_a_data, rd_b_data  out  32  read-port data.
REQ-013 flag_q, tpc_q, ipc_q, sp_q, tlb_q  out  32  always-visible special registers.
REQ-014 int_pending  out  1  an interrupt is latched and awaiting ack.
REQ-015 int_num_q  out  8  vector of the latched interrupt.
REQ-016 int_overrun  out  1  sticky: a request arrived while one was already pending.

Function
REQ-017 Register select encoding SHALL be 1-8 r1-r8, 9 flag, 11 tpc, 12 ipc, 13 sp, 14 tlb; selects 0, 10 and 15 read 32'h0.
REQ-018 Each register SHALL load its data input on a clk edge where its _c is 1 and SHALL hold its value otherwise; data inputs are ignored, including z/x, when _c is 0.
REQ-019 Any number of _c inputs may be 1 in the same cycle, and every enabled register SHALL be written in that cycle.
REQ-020 Read ports SHALL be combinational, with same-cycle bypass: if the selected register's _c is 1, rd_x_data equals the incoming data, otherwise the stored value.
REQ-021 flag_q..tlb_q SHALL show stored values without bypass.
REQ-022 Interrupt FSM states are IDLE and PENDING; int_pending = (state == PENDING).
REQ-023 IDLE -> PENDING on int_in = 1, latching int_num_in into int_num_q.
REQ-024 PENDING -> IDLE on int_ack = 1.
REQ-025 In PENDING, int_in without int_ack SHALL keep the first int_num_q and set int_overrun.
REQ-026 If int_ack and int_in are both 1 in PENDING, the state SHALL remain PENDING with the new int_num_in latched, and int_overrun SHALL stay unchanged.
REQ-027 int_ack in IDLE SHALL be ignored.
REQ-028 int_overrun SHALL clear only on rst.

Reset
REQ-029 On rst, r1-r8, flag, ipc and tlb SHALL be cleared to 0, sp SHALL load SP_RESET, and tpc SHALL load TPC_RESET.
REQ-030 On rst, the FSM SHALL enter IDLE, int_num_q SHALL be 0 and int_overrun SHALL be 0.
REQ-031 rst SHALL take priority over any simultaneous write, int_in or int_ack.
REQ-032 The first edge after rst deasserts SHALL operate normally.

Structure
REQ-033 Register select codes and FSM state encodings SHALL live in a shared package or include file, also used by the write-back and decode stages.
REQ-034 The interrupt latch FSM SHALL be one sub-module, int_latch; the register array and read muxes stay in register_bank.

Verification
REQ-035 Reset value check: assert rst with SP_RESET = 32'h0000_1000 -> sp_q = 32'h1000, all other registers 0, int_pending = 0.
REQ-036 Write and bypass check:
- r3_c = 1 with r3 = 32'hDEAD_BEEF and rd_a_sel = 3 -> rd_a_data = DEADBEEF in the same cycle and stays DEADBEEF after r3_c drops.
- r3 = z with r3_c = 0 -> the stored value is unchanged.
REQ-037 Simultaneous writes: flag_c, sp_c and r5_c all 1 with distinct data -> all three update on one edge, and rd_b_sel = 10 reads 0.
REQ-038 Interrupt handshake:
- int_in = 1 with int_num_in = 8 -> int_pending = 1 and int_num_q = 8 on the next cycle.
- int_ack pulse -> int_pending = 0 on the next cycle.
REQ-039 Overrun:
- while PENDING (num 8), int_in with num 3 and no ack -> int_num_q stays 8 and int_overrun = 1.
- int_ack and int_in (num 5) together -> stays PENDING with int_num_q = 5.
REQ-040 Reset mid-operation: rst asserted while PENDING with r1 being written -> IDLE, r1 = 0 and int_overrun = 0 on the next edge.
